cgra_cfg_fetch_ctrl: RTL and testbench

Configuration-context fetch sequencer sitting between the CGRA configuration memory read port and the fabric's configuration load path. On a start command it walks a contiguous block of 64-bit configuration words, issues one-cycle-latency reads to the memory, buffers returned words in a small credit-managed FIFO, and streams them downstream over a valid/ready interface. It tags the final word and pulses completion. Backpressure on the output never drops or duplicates a word.

---
 rtl/cgra_cfg_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_cgra_cfg_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_cfg_fetch_ctrl.sv
// Config-context fetch: walks a 64-bit word block via 1-cycle memory reads and streams it downstream.
// Latency: start->first read 1 cycle, ->first output 3 cycles; 1 word/cycle sustained for BUF_DEPTH>=3.
// Backpressure: reads are credit-gated on FIFO space; output held stable while stalled. Option: CFG_FETCH_CHECKSUM_EN.
module cgra_cfg_fetch_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 10,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  num_words_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_ren_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_valid_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i
`ifdef CFG_FETCH_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_WIDTH-1:0]   issue_cnt_q, accept_cnt_q;
    logic                   inflight_q, drop_q;
    logic [DATA_WIDTH-1:0]  fifo_mem [BUF_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   abort_act, start_acc, push, pop, credit_ok;
    logic [CW:0]            occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign abort_act   = abort_i && (state_q != S_IDLE);
    assign start_acc   = start_i && (state_q == S_IDLE);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = fifo_mem[rd_ptr_q];
    assign out_last_o  = out_valid_o && (accept_cnt_q == CNT_WIDTH'(1));
    assign pop         = out_valid_o && out_ready_i;
    // A read issued last cycle lands in the FIFO this cycle, so it already owns a slot.
    assign push        = mem_valid_i && !drop_q && !abort_act;
    assign occ         = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    assign credit_ok   = occ < ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop));
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE) && !abort_act;
    assign mem_addr_o  = addr_q;

    always_comb begin
        state_d   = state_q;
        mem_ren_o = 1'b0;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (num_words_i == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (credit_ok) begin
                mem_ren_o = 1'b1;
                if (issue_cnt_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: if (pop && accept_cnt_q == CNT_WIDTH'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_act) begin
            state_d   = S_IDLE;
            mem_ren_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            inflight_q   <= 1'b0;
            drop_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_ren_o;
            drop_q     <= abort_act;
            if (abort_act) begin
                issue_cnt_q  <= '0;
                accept_cnt_q <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
            end else begin
                if (start_acc) begin
                    addr_q       <= base_addr_i & ~ADDR_WIDTH'(7);
                    issue_cnt_q  <= num_words_i;
                    accept_cnt_q <= num_words_i;
                end
                if (mem_ren_o) begin
                    addr_q      <= addr_q + ADDR_WIDTH'(8);
                    issue_cnt_q <= issue_cnt_q - CNT_WIDTH'(1);
                end
                if (pop) accept_cnt_q <= accept_cnt_q - CNT_WIDTH'(1);
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata_i;
        end
    end

`ifdef CFG_FETCH_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     checksum_o <= '0;
        else if (abort_act || start_acc) checksum_o <= '0;
        else if (pop)                   checksum_o <= checksum_o ^ out_data_o;
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_cgra_cfg_fetch_ctrl.sv
// Randomized bench for cgra_cfg_fetch_ctrl against a queue-based reference of the fetched word stream.
module tb_cgra_cfg_fetch_ctrl;
    localparam int DW = 64, AW = 32, CNTW = 10, DEPTH = 4;

    logic            clk = 0, rst_n = 0;
    logic            start_i = 0, abort_i = 0;
    logic [AW-1:0]   base_addr_i = '0;
    logic [CNTW-1:0] num_words_i = '0;
    logic            busy_o, done_o, mem_ren_o, out_valid_o, out_last_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_rdata_i, out_data_o;
    logic            mem_valid_i;
    logic            out_ready_i = 0;
`ifdef CFG_FETCH_CHECKSUM_EN
    logic [DW-1:0]   checksum_o;
`endif

    cgra_cfg_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CNTW), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_words_i(num_words_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .mem_addr_o(mem_addr_o), .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i),
        .mem_valid_i(mem_valid_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i)
`ifdef CFG_FETCH_CHECKSUM_EN
        , .checksum_o(checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int t_start = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: explicit preloads, otherwise an address-derived pattern.
    logic [63:0] mem_init [logic [31:0]];
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_i <= 1'b0;
            mem_rdata_i <= '0;
        end else begin
            mem_valid_i <= mem_ren_o;
            mem_rdata_i <= mem_word(mem_addr_o);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ($urandom_range(0, 9) < 7);
                default: out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
        end
    end

    // Reference model: the word stream the transfer must deliver, in order.
    logic [63:0] exp_q [$];
    logic [31:0] exp_addr;
    int          issue_left, issued, popped;
    logic [63:0] cks_model;
    logic        prev_stall = 0, prev_last;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check_eq("stall_valid", out_valid_o, 1'b1);
                check_eq("stall_data", out_data_o, prev_data);
                check_eq("stall_last", out_last_o, prev_last);
            end
            if (mem_ren_o) begin
                check_eq("ren_expected", issue_left != 0, 1'b1);
                check_eq("ren_addr", mem_addr_o, exp_addr);
                exp_addr = exp_addr + 32'd8;
                if (issue_left > 0) issue_left--;
                issued++;
            end
            if (out_valid_o && out_ready_i) begin
                check_eq("pop_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check_eq("out_data", out_data_o, exp_q[0]);
                    check_eq("out_last", out_last_o, exp_q.size() == 1);
                    cks_model = cks_model ^ exp_q[0];
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            check_eq("credit", (issued - popped) <= DEPTH, 1'b1);
            prev_stall = out_valid_o && !out_ready_i && !abort_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
        end
    end

    task automatic start_xfer(input logic [31:0] base, input int n);
        logic [31:0] al;
        @(posedge clk);
        #1;
        al = base & ~32'd7;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(al + 32'(8 * i)));
        exp_addr   = al;
        issue_left = n;
        issued     = 0;
        popped     = 0;
        cks_model  = '0;
        start_i     = 1'b1;
        base_addr_i = base;
        num_words_i = CNTW'(n);
        t_start     = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic finish_xfer(input int n, input bit timed);
        int done_at = -1;
        for (int i = 0; i < 20 * n + 60; i++) begin
            @(negedge clk);
            if (done_o) begin
                done_at = cyc;
                break;
            end
        end
        check_eq("done_seen", done_at != -1, 1'b1);
        if (done_at != -1) check_eq("busy_at_done", busy_o, 1'b1);
        if (timed) check_eq("done_cycle", done_at, (n == 0) ? t_start + 1 : t_start + 3 + n);
        check_eq("words_left", exp_q.size(), 0);
        check_eq("words_issued", issued, n);
`ifdef CFG_FETCH_CHECKSUM_EN
        check_eq("checksum", checksum_o, cks_model);
`endif
        @(negedge clk);
        check_eq("idle_busy", busy_o, 1'b0);
        check_eq("idle_done", done_o, 1'b0);
    endtask

    task automatic run_xfer(input logic [31:0] base, input int n, input int mode);
        rdy_mode = mode;
        start_xfer(base, n);
        finish_xfer(n, mode == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_init[32'h100] = 64'hA0;
        mem_init[32'h108] = 64'hA1;
        mem_init[32'h110] = 64'hA2;
        mem_init[32'h118] = 64'hA3;
        mem_init[32'h3000] = 64'hF0;
        mem_init[32'h3008] = 64'h0F;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_ren", mem_ren_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_valid", out_valid_o, 1'b0);
        check_eq("rst_last", out_last_o, 1'b0);
        check_eq("rst_addr", mem_addr_o, 32'd0);
        check_eq("rst_data", out_data_o, 64'd0);
`ifdef CFG_FETCH_CHECKSUM_EN
        check_eq("rst_checksum", checksum_o, 64'd0);
`endif

        run_xfer(32'h100, 4, 0);
        run_xfer(32'h203, 2, 0);
        run_xfer(32'h1000, 8, 2);
        run_xfer(32'h500, 0, 0);
        run_xfer(32'hFFFF_FFF3, 4, 0);

        // Abort while the fifth word is on the output.
        rdy_mode = 0;
        start_xfer(32'h2000, 16);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (popped == 4 && out_valid_o) begin
                abort_i = 1'b1;
                break;
            end
        end
        check_eq("abort_reached", abort_i, 1'b1);
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        exp_q.delete();
        issue_left = 0;
        @(negedge clk);
        check_eq("abort_busy", busy_o, 1'b0);
        check_eq("abort_valid", out_valid_o, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", done_o, 1'b0);
            check_eq("abort_no_data", out_valid_o, 1'b0);
        end
        run_xfer(32'h4000, 1, 0);

        // A second start mid-transfer must not disturb the running one.
        rdy_mode = 0;
        start_xfer(32'h3000, 2);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = 32'h9000;
        num_words_i = CNTW'(3);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        finish_xfer(2, 1'b1);
`ifdef CFG_FETCH_CHECKSUM_EN
        check_eq("checksum_ff", checksum_o, 64'hFF);
`endif

        for (int k = 0; k < 12; k++) begin
            run_xfer($urandom, $urandom_range(1, 40), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
